load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle RV32I load/store unit sitting between the execute stage and the register file write port. It takes a computed effective address, funct3 and store operand, runs one data-memory transaction over a ready/valid-style bus, and formats load results. It drives the register file write triplet (RD, RD_DATA, REG_WRITE_ENABLE) for loads. Misaligned, illegal-funct3 and timed-out accesses are flagged and never write the register file.

## Interface
- TIMEOUT, 255: maximum wait cycles for MEM_READY before aborting with ERROR; range 1..255.
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request; accepted only when BUSY=0
- IS_STORE  in  1  1 = store, 0 = load
- FUNCT3  in  3  RV32I width/sign code
- ADDR  in  32  effective byte address
- STORE_DATA  in  32  store operand (rs2 value)
- RD_IN  in  5  load destination register
- MEM_REQ  out  1  bus request, held until MEM_READY
- MEM_WE  out  1  1 = write transaction
- MEM_ADDR  out  32  word address ({ADDR[31:2],2'b00})
- MEM_WDATA  out  32  lane-replicated store data
- MEM_WSTRB  out  4  byte-lane enables (0000 on reads)
- MEM_READY  in  1  transaction complete this cycle
- MEM_RDATA  in  32  read word, valid when MEM_READY=1
- RD  out  5  register file destination
- RD_DATA  out  32  formatted load result
- REG_WRITE_ENABLE  out  1  one-cycle write pulse
- BUSY  out  1  unit not idle
- DONE  out  1  one-cycle completion pulse (success)
- ERROR  out  1  one-cycle error pulse

## Operation
- States: IDLE, ACCESS, WB.
- IDLE: START=1 latches IS_STORE, FUNCT3, ADDR, STORE_DATA, RD_IN. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Misaligned: halfword with ADDR[0]=1; word with ADDR[1:0]≠00.
- Illegal or misaligned: no bus transaction; ERROR pulses next cycle; stays IDLE.
- Legal: -> ACCESS; MEM_REQ=1, MEM_WE=IS_STORE, outputs stable until MEM_READY.
- Store lanes: SB data={4{b}}, strobe 0001<<ADDR[1:0]; SH data={2{h}}, strobe 0011<<ADDR[1:0]; SW strobe 1111.
- ACCESS, MEM_READY=1: MEM_RDATA captured and shifted right by 8*ADDR[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; -> WB.
- ACCESS, no MEM_READY for TIMEOUT cycles: MEM_REQ drops, ERROR pulses, -> IDLE; no write.
- WB (one cycle): DONE=1. Load with RD_IN≠0: REG_WRITE_ENABLE=1, RD=RD_IN, RD_DATA=result. Store, or load to x0: REG_WRITE_ENABLE=0. -> IDLE.
- START while BUSY=1 is ignored (no queueing).

## Timing
- Reset (async, immediate): state IDLE; MEM_REQ, MEM_WE, MEM_WSTRB, MEM_ADDR, MEM_WDATA, RD, RD_DATA, REG_WRITE_ENABLE, BUSY, DONE, ERROR all 0; wait counter 0. Reset mid-ACCESS drops MEM_REQ without waiting for MEM_READY.
- START at edge N -> MEM_REQ=1 and BUSY=1 from cycle N+1.
- MEM_READY sampled at edge M -> WB in cycle M+1 (DONE, REG_WRITE_ENABLE) -> BUSY=0 in cycle M+2.
- Zero-wait memory (MEM_READY same cycle as first MEM_REQ): START to write pulse = 2 cycles; next START accepted in cycle M+2.
- Timeout: ERROR in the cycle after the TIMEOUT-th non-ready ACCESS cycle; MEM_READY arriving in that same sampled cycle wins (completes normally).
- Error pulse for illegal/misaligned: cycle N+1; BUSY stays 0.
- RD/RD_DATA hold their last values outside WB; only REG_WRITE_ENABLE qualifies them.

## Test plan
- LW ADDR=0x100, RD_IN=5, MEM_READY after 2 waits, MEM_RDATA=0xDEADBEEF -> MEM_ADDR=0x100, WSTRB=0000; WB: RD=5, RD_DATA=0xDEADBEEF, one-cycle REG_WRITE_ENABLE and DONE.
- LB ADDR=0x103, MEM_RDATA=0x80112233 -> RD_DATA=0xFFFFFF80; LBU same -> 0x00000080; LHU ADDR=0x102 -> 0x00008011.
- SB ADDR=0x201, STORE_DATA=0x000000AB -> MEM_WE=1, MEM_ADDR=0x200, MEM_WDATA=0xABABABAB, WSTRB=0010; DONE, no REG_WRITE_ENABLE.
- LW ADDR=0x102 and load FUNCT3=011 -> ERROR next cycle, MEM_REQ never asserted, no write.
- Load, MEM_READY held 0, TIMEOUT=4 -> MEM_REQ high 4 cycles, then ERROR, BUSY=0, no write; START during ACCESS ignored.
- LW RD_IN=0 -> transaction and DONE occur, REG_WRITE_ENABLE stays 0; RST_N low mid-ACCESS -> MEM_REQ, BUSY 0 immediately.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// The unit holds a request until the memory answers with mem_ready.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one data-memory transaction per request, load result
// formatting and a registered register-file write port. Illegal, misaligned and
// timed-out accesses raise a one-cycle error and never write the register file.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  input  logic [4:0]                rd_in,
  load_store_unit_if.master         mem,
  output logic [4:0]                rd,
  output logic [31:0]               rd_data,
  output logic                      reg_write_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWb     = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  rd_in_q, rd_in_d;
  logic [7:0]  wait_q, wait_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rwe_q, rwe_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        req_legal;
  logic        req_misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rdata_shifted;
  logic [31:0] load_result;

  // Decode the incoming request: funct3 legality, alignment and store lanes.
  always_comb begin
    req_legal = 1'b0;
    if (is_store) begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    end
    req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Align the read word to the accessed byte and sign/zero-extend.
  always_comb begin
    rdata_shifted = mem.mem_rdata >> {offset_q, 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_result = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_result = {24'h000000, rdata_shifted[7:0]};
      3'b101:  load_result = {16'h0000, rdata_shifted[15:0]};
      default: load_result = rdata_shifted;
    endcase
  end

  // Next-state logic for the IDLE -> ACCESS -> WB sequence.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    rd_in_d     = rd_in_q;
    wait_d      = wait_q;
    rd_d        = rd_q;
    rd_data_d   = rd_data_q;
    rwe_d       = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          offset_d   = addr[1:0];
          rd_in_d    = rd_in;
          if (!req_legal || req_misaligned) begin
            error_d = 1'b1;
          end else begin
            state_d     = StAccess;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_wstrb_d = is_store ? lane_wstrb : 4'b0000;
            wait_d      = 8'd0;
          end
        end
      end
      StAccess: begin
        // A ready in the last allowed wait cycle still completes normally.
        if (mem.mem_ready) begin
          state_d     = StWb;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wait_d      = 8'd0;
          done_d      = 1'b1;
          if (!is_store_q && (rd_in_q != 5'd0)) begin
            rwe_d     = 1'b1;
            rd_d      = rd_in_q;
            rd_data_d = load_result;
          end
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          state_d     = StIdle;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          wait_d      = 8'd0;
          error_d     = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'b0000;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      offset_q    <= 2'd0;
      rd_in_q     <= 5'd0;
      wait_q      <= 8'd0;
      rd_q        <= 5'd0;
      rd_data_q   <= 32'd0;
      rwe_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      rd_in_q     <= rd_in_d;
      wait_q      <= wait_d;
      rd_q        <= rd_d;
      rd_data_q   <= rd_data_d;
      rwe_q       <= rwe_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign mem.mem_req       = mem_req_q;
  assign mem.mem_we        = mem_we_q;
  assign mem.mem_addr      = mem_addr_q;
  assign mem.mem_wdata     = mem_wdata_q;
  assign mem.mem_wstrb     = mem_wstrb_q;
  assign rd                = rd_q;
  assign rd_data           = rd_data_q;
  assign reg_write_enable  = rwe_q;
  assign busy              = (state_q != StIdle);
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized requests against a
// byte-arithmetic reference model, with a memory that answers after N waits.
module tb_load_store_unit;
  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        reg_write_enable;
  logic        busy;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .is_store         (is_store),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .rd_in            (rd_in),
    .mem              (bus.master),
    .rd               (rd),
    .rd_data          (rd_data),
    .reg_write_enable (reg_write_enable),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes from funct3.
  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit exp_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (st) ok = (f3 <= 3'd2);
    else    ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if (f3[1:0] == 2'b11) ok = 1'b0;
    return ok && ((a % 32'(size_of(f3))) == 32'd0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int     nb;
    longint v;
    longint m;
    nb = size_of(f3);
    v  = longint'(w >> (8 * (a % 4)));
    m  = (longint'(1) << (8 * nb)) - 1;
    v  = v & m;
    if (!f3[2] && nb < 4 && v > (m >> 1)) v = v - (m + 1);
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (size_of(f3))
      1:       return (sd & 32'h000000FF) * 32'h01010101;
      2:       return (sd & 32'h0000FFFF) * 32'h00010001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [31:0] a);
    return 4'(((1 << size_of(f3)) - 1) << (a % 4));
  endfunction

  // Issue one request and follow it cycle by cycle; waits >= TIMEOUT times out.
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rdi, input int waits,
                        input logic [31:0] rdata, input bit noise);
    bit legal;
    bit completed;
    bit exp_wr;
    legal     = exp_legal(st, f3, a);
    completed = 1'b0;
    exp_wr    = !st && (rdi != 5'd0);
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rdi;
    @(negedge clk);
    start = 1'b0;
    is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom;
    store_data = $urandom; rd_in = 5'($urandom);
    if (!legal) begin
      check_eq("err_pulse", 32'(error), 32'd1);
      check_eq("err_no_req", 32'(bus.mem_req), 32'd0);
      check_eq("err_busy", 32'(busy), 32'd0);
      check_eq("err_no_wr", 32'(reg_write_enable), 32'd0);
      @(negedge clk);
      check_eq("err_one_cycle", 32'(error), 32'd0);
      check_eq("err_no_req2", 32'(bus.mem_req), 32'd0);
      return;
    end
    check_eq("no_err", 32'(error), 32'd0);
    for (int k = 0; k < int'(TIMEOUT) && !completed; k++) begin
      check_eq("req", 32'(bus.mem_req), 32'd1);
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("we", 32'(bus.mem_we), 32'(st));
      check_eq("maddr", bus.mem_addr, a & 32'hFFFF_FFFC);
      check_eq("wstrb", 32'(bus.mem_wstrb), st ? 32'(exp_wstrb(f3, a)) : 32'd0);
      if (st) check_eq("wdata", bus.mem_wdata, exp_wdata(f3, sd));
      check_eq("acc_done", 32'(done), 32'd0);
      if (noise) begin
        start = 1'($urandom); is_store = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom;
      end
      if (k == waits) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(negedge clk);
      start = 1'b0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = $urandom;
      if (k == waits) completed = 1'b1;
    end
    if (completed) begin
      check_eq("wb_done", 32'(done), 32'd1);
      check_eq("wb_busy", 32'(busy), 32'd1);
      check_eq("wb_req", 32'(bus.mem_req), 32'd0);
      check_eq("wb_err", 32'(error), 32'd0);
      check_eq("wb_we", 32'(reg_write_enable), 32'(exp_wr));
      if (exp_wr) begin
        check_eq("wb_rd", 32'(rd), 32'(rdi));
        check_eq("wb_data", rd_data, exp_load(f3, a, rdata));
      end
      @(negedge clk);
      check_eq("post_done", 32'(done), 32'd0);
      check_eq("post_we", 32'(reg_write_enable), 32'd0);
      check_eq("post_busy", 32'(busy), 32'd0);
    end else begin
      check_eq("to_err", 32'(error), 32'd1);
      check_eq("to_req", 32'(bus.mem_req), 32'd0);
      check_eq("to_busy", 32'(busy), 32'd0);
      check_eq("to_we", 32'(reg_write_enable), 32'd0);
      check_eq("to_done", 32'(done), 32'd0);
      @(negedge clk);
      check_eq("to_err_off", 32'(error), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    rst_n = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    store_data = 32'd0; rd_in = 5'd0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'd0);
    check_eq("rst_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_rwe", 32'(reg_write_enable), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 2, 32'hDEADBEEF, 1'b0);
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd1, 0, 32'h80112233, 1'b0);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd2, 1, 32'h80112233, 1'b0);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 5'd3, 0, 32'h80112233, 1'b0);
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd4, 0, 32'h80112233, 1'b0);
    run_op(1'b1, 3'b000, 32'h201, 32'h000000AB, 5'd9, 1, 32'h0, 1'b0);
    run_op(1'b1, 3'b001, 32'h202, 32'h1234BEEF, 5'd9, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 5'd9, 3, 32'h0, 1'b0);
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b011, 32'h100, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    run_op(1'b1, 3'b100, 32'h100, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 5'd5, 0, 32'h0, 1'b0);
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 5'd6, 10, 32'h0, 1'b1);
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 5'd6, int'(TIMEOUT) - 1, 32'h55AA1234, 1'b1);
    run_op(1'b0, 3'b010, 32'h308, 32'h0, 5'd0, 0, 32'h12345678, 1'b0);

    // Reset in the middle of an access drops the request at once.
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; rd_in = 5'd7;
    @(negedge clk);
    start = 1'b0;
    check_eq("mid_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_req", 32'(bus.mem_req), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 3'b000, 32'h405, 32'h0, 5'd8, 1, 32'h00007F00, 1'b0);

    // Randomized requests.
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) != 0) ra = ra & 32'hFFFF_FFFC | 32'($urandom_range(0, 3) & 1);
      run_op(1'($urandom), 3'($urandom), ra, $urandom, 5'($urandom),
             int'($urandom_range(0, 5)), $urandom, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
